// File: rtl/zx_video_out.sv
// zx_video_out - colour/sync output stage behind the Spectrum ULA.
//
// Samples the ULA's pixel colour (standard IGRB or ULA+ GGGRRRBB), syncs
// and blanks on the ULA pixel enables. It maps the colour to 8-bit RGB,
// applies ULA+ greyscale and blank forcing, and delays the syncs and blanks
// through the same three stages so that they stay aligned with the colour.
//
// Ports
//   clk_sys              in   master clock
//   reset                in   synchronous, active-high
//   ce_7mp / ce_7mn      in   ULA 7 MHz positive / negative phase enables
//   I, R, G, B           in   standard palette colour
//   ulap_color[7:0]      in   ULA+ palette entry, GGGRRRBB
//   ulap_ena / ulap_mono in   select ULA+ colour / greyscale output
//   mode512              in   Timex 512-pixel mode requested for next frame
//   HSync, VSync         in   ULA syncs, active-high
//   HBlank, VBlank       in   ULA blanks, active-high
//   ce_pix               out  one pulse per output pixel
//   r_out/g_out/b_out    out  8-bit colour, 0 while blanked
//   hs_out, vs_out       out  delayed syncs
//   hbl_out, vbl_out     out  delayed blanks
//   de_out               out  display enable
//   hires                out  512-pixel mode in force for this frame
module zx_video_out #(
   parameter logic [7:0] NORM_LVL = 8'hD7,
   parameter logic [7:0] BRT_LVL  = 8'hFF
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce_7mp,
   input  logic       ce_7mn,
   input  logic       I,
   input  logic       R,
   input  logic       G,
   input  logic       B,
   input  logic [7:0] ulap_color,
   input  logic       ulap_ena,
   input  logic       ulap_mono,
   input  logic       mode512,
   input  logic       HSync,
   input  logic       VSync,
   input  logic       HBlank,
   input  logic       VBlank,
   output logic       ce_pix,
   output logic [7:0] r_out,
   output logic [7:0] g_out,
   output logic [7:0] b_out,
   output logic       hs_out,
   output logic       vs_out,
   output logic       hbl_out,
   output logic       vbl_out,
   output logic       de_out,
   output logic       hires
);

   function automatic logic [7:0] std_lvl(input logic on, input logic brt);
      return on ? (brt ? BRT_LVL : NORM_LVL) : 8'h00;
   endfunction

   // Replicate a 3-bit ULA+ component so that 3'b111 maps to 8'hFF.
   function automatic logic [7:0] up3(input logic [2:0] v);
      return {v, v, v[2:1]};
   endfunction

   // Luma truncated from a 16-bit sum; the weights add up to 256, so full
   // white stays at 8'hFF.
   function automatic logic [7:0] grey(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
      logic [15:0] y;
      y = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
      return y[15:8];
   endfunction

   logic       hires_lat;
   logic       smp;

   logic       vld_p1, i_p1, r_p1, g_p1, b_p1;
   logic [7:0] ucol_p1;
   logic       uena_p1, umono_p1, hs_p1, vs_p1, hbl_p1, vbl_p1;

   logic       vld_p2;
   logic [7:0] r_p2, g_p2, b_p2;
   logic       mono_p2, hs_p2, vs_p2, hbl_p2, vbl_p2;

   logic [7:0] r24_p1, g24_p1, b24_p1;
   logic [2:0] b3_p1;
   logic [7:0] y_p2;
   logic       blank_p2;

   // A coincident ce_7mp/ce_7mn still yields a single sample.
   assign smp   = ce_7mn | (hires_lat & ce_7mp);
   assign hires = hires_lat;

   // ---- stage 1 -> stage 2: palette mapping ----
   always_comb begin
      b3_p1  = {ucol_p1[1], ucol_p1[0], ucol_p1[1] | ucol_p1[0]};
      r24_p1 = std_lvl(r_p1, i_p1);
      g24_p1 = std_lvl(g_p1, i_p1);
      b24_p1 = std_lvl(b_p1, i_p1);
      if (uena_p1) begin
         r24_p1 = up3(ucol_p1[4:2]);
         g24_p1 = up3(ucol_p1[7:5]);
         b24_p1 = up3(b3_p1);
      end
   end

   // ---- stage 2 -> stage 3: greyscale and blank forcing ----
   always_comb begin
      y_p2     = grey(r_p2, g_p2, b_p2);
      blank_p2 = hbl_p2 | vbl_p2;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hires_lat <= 1'b0;
         ce_pix    <= 1'b0;
         vld_p1    <= 1'b0;
         i_p1      <= 1'b0;
         r_p1      <= 1'b0;
         g_p1      <= 1'b0;
         b_p1      <= 1'b0;
         ucol_p1   <= 8'h00;
         uena_p1   <= 1'b0;
         umono_p1  <= 1'b0;
         hs_p1     <= 1'b0;
         vs_p1     <= 1'b0;
         hbl_p1    <= 1'b0;
         vbl_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         r_p2      <= 8'h00;
         g_p2      <= 8'h00;
         b_p2      <= 8'h00;
         mono_p2   <= 1'b0;
         hs_p2     <= 1'b0;
         vs_p2     <= 1'b0;
         hbl_p2    <= 1'b0;
         vbl_p2    <= 1'b0;
         r_out     <= 8'h00;
         g_out     <= 8'h00;
         b_out     <= 8'h00;
         hs_out    <= 1'b0;
         vs_out    <= 1'b0;
         hbl_out   <= 1'b0;
         vbl_out   <= 1'b0;
         de_out    <= 1'b0;
      end else begin
         ce_pix <= smp;
         if (smp) begin
            // Pixel rate may only change at the start of vertical blank.
            if (VBlank && !vbl_p1) hires_lat <= mode512;

            // ---- stage 1: capture ULA outputs ----
            vld_p1   <= 1'b1;
            i_p1     <= I;
            r_p1     <= R;
            g_p1     <= G;
            b_p1     <= B;
            ucol_p1  <= ulap_color;
            uena_p1  <= ulap_ena;
            umono_p1 <= ulap_mono;
            hs_p1    <= HSync;
            vs_p1    <= VSync;
            hbl_p1   <= HBlank;
            vbl_p1   <= VBlank;

            // ---- stage 2: RGB24 ----
            vld_p2  <= vld_p1;
            r_p2    <= r24_p1;
            g_p2    <= g24_p1;
            b_p2    <= b24_p1;
            mono_p2 <= uena_p1 & umono_p1;
            hs_p2   <= hs_p1;
            vs_p2   <= vs_p1;
            hbl_p2  <= hbl_p1;
            vbl_p2  <= vbl_p1;

            // ---- stage 3: outputs ----
            r_out   <= blank_p2 ? 8'h00 : (mono_p2 ? y_p2 : r_p2);
            g_out   <= blank_p2 ? 8'h00 : (mono_p2 ? y_p2 : g_p2);
            b_out   <= blank_p2 ? 8'h00 : (mono_p2 ? y_p2 : b_p2);
            hs_out  <= hs_p2;
            vs_out  <= vs_p2;
            hbl_out <= hbl_p2;
            vbl_out <= vbl_p2;
            // Held low until real data has reached the output after reset.
            de_out  <= vld_p2 & ~blank_p2;
         end
      end
   end

endmodule

// File: tb/tb_zx_video_out.sv
// tb_zx_video_out - randomized and directed bench for zx_video_out with a
// sample-history reference model.
module tb_zx_video_out;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, ce_7mp = 1'b0, ce_7mn = 1'b0;
   logic       in_i = 1'b0, in_r = 1'b0, in_g = 1'b0, in_b = 1'b0;
   logic [7:0] ucol = 8'h00;
   logic       uena = 1'b0, umono = 1'b0, mode512 = 1'b0;
   logic       hsync = 1'b0, vsync = 1'b0, hblank = 1'b0, vblank = 1'b0;

   logic       ce_pix, hs_out, vs_out, hbl_out, vbl_out, de_out, hires;
   logic [7:0] r_out, g_out, b_out;

   zx_video_out dut (
      .clk_sys(clk), .reset(reset), .ce_7mp(ce_7mp), .ce_7mn(ce_7mn),
      .I(in_i), .R(in_r), .G(in_g), .B(in_b),
      .ulap_color(ucol), .ulap_ena(uena), .ulap_mono(umono), .mode512(mode512),
      .HSync(hsync), .VSync(vsync), .HBlank(hblank), .VBlank(vblank),
      .ce_pix(ce_pix), .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .hs_out(hs_out), .vs_out(vs_out), .hbl_out(hbl_out), .vbl_out(vbl_out),
      .de_out(de_out), .hires(hires)
   );

   int vectors = 0;
   int miscompares = 0;
   int pixcount = 0;

   typedef struct packed {
      logic       i, r, g, b;
      logic [7:0] uc;
      logic       ue, um, hs, vs, hb, vb;
   } smp_t;

   smp_t        hist[$];
   bit          hires_m = 1'b0, prev_vbl_m = 1'b0;
   logic        exp_ce = 1'b0, exp_hires = 1'b0;
   logic [28:0] exp_pix = '0;   // {r,g,b,hs,vs,hbl,vbl,de}

   function automatic int lvl(bit on, bit brt);
      return on ? (brt ? 255 : 215) : 0;
   endfunction

   function automatic int up3(int v);
      return v * 32 + v * 4 + v / 2;
   endfunction

   function automatic logic [28:0] expect_pix(smp_t s);
      int r8, g8, b8, b2, y;
      logic [7:0] r, g, b;
      if (s.ue) begin
         r8 = up3(int'(s.uc[4:2]));
         g8 = up3(int'(s.uc[7:5]));
         b2 = int'(s.uc[1:0]);
         b8 = up3(b2 * 2 + ((b2 != 0) ? 1 : 0));
         if (s.um) begin
            y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
            r8 = y; g8 = y; b8 = y;
         end
      end else begin
         r8 = lvl(s.r, s.i);
         g8 = lvl(s.g, s.i);
         b8 = lvl(s.b, s.i);
      end
      if (s.hb || s.vb) begin
         r8 = 0; g8 = 0; b8 = 0;
      end
      r = r8[7:0]; g = g8[7:0]; b = b8[7:0];
      return {r, g, b, s.hs, s.vs, s.hb, s.vb, !(s.hb || s.vb)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Advance the model for the inputs now applied, then let one clock pass.
   task automatic step();
      smp_t cur;
      bit   s;
      cur = '{i: in_i, r: in_r, g: in_g, b: in_b, uc: ucol, ue: uena, um: umono,
              hs: hsync, vs: vsync, hb: hblank, vb: vblank};
      if (reset) begin
         hist.delete();
         hires_m = 1'b0; prev_vbl_m = 1'b0;
         exp_ce = 1'b0; exp_pix = '0;
      end else begin
         s = ce_7mn | (hires_m & ce_7mp);
         exp_ce = s;
         if (s) begin
            if (vblank && !prev_vbl_m) hires_m = mode512;
            prev_vbl_m = vblank;
            hist.push_back(cur);
            if (hist.size() > 3) void'(hist.pop_front());
            if (hist.size() == 3) exp_pix = expect_pix(hist[0]);
         end
      end
      exp_hires = hires_m;
      @(negedge clk);
      pixcount += int'(ce_pix);
   endtask

   task automatic pulse_n(input int n);
      repeat (n) begin
         ce_7mn = 1'b1; step();
         ce_7mn = 1'b0; repeat (7) step();
      end
   endtask

   task automatic pulse_pn(input int n);
      repeat (n) begin
         ce_7mp = 1'b1; step();
         ce_7mp = 1'b0; repeat (3) step();
         ce_7mn = 1'b1; step();
         ce_7mn = 1'b0; repeat (3) step();
      end
   endtask

   task automatic set_igrb(input logic [3:0] v);
      {in_i, in_g, in_r, in_b} = v;
   endtask

   // Per-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      vectors++;
      if ({ce_pix, r_out, g_out, b_out, hs_out, vs_out, hbl_out, vbl_out, de_out, hires}
          !== {exp_ce, exp_pix, exp_hires}) begin
         miscompares++;
         $display("FAIL cycle t=%0t: got ce=%b pix=%h hires=%b, expected ce=%b pix=%h hires=%b",
                  $time, ce_pix, {r_out, g_out, b_out, hs_out, vs_out, hbl_out, vbl_out, de_out},
                  hires, exp_ce, exp_pix, exp_hires);
      end
   end

   initial begin
      smp_t t;
      // Model pinned to hand-computed values.
      t = '0; t.i = 1; t.r = 1;
      chk("model_igrb1010", {8'h0, expect_pix(t)[28:5]}, 32'h00FF0000);
      t = '0; t.g = 1; t.r = 1; t.b = 1;
      chk("model_igrb0111", {8'h0, expect_pix(t)[28:5]}, 32'h00D7D7D7);
      t = '0; t.ue = 1; t.uc = 8'hE3;
      chk("model_ulap_e3", {8'h0, expect_pix(t)[28:5]}, 32'h0000FFFF);
      t.um = 1;
      chk("model_mono_e3", {8'h0, expect_pix(t)[28:5]}, 32'h00B2B2B2);
      t.uc = 8'hFF;
      chk("model_mono_ff", {8'h0, expect_pix(t)[28:5]}, 32'h00FFFFFF);

      // Reset state.
      reset = 1'b1; step(); step();
      chk("reset_state", {22'h0, ce_pix, de_out, hires, hs_out, vs_out, hbl_out, vbl_out,
                          r_out == 8'h00, g_out == 8'h00, b_out == 8'h00}, 32'h0000_0007);
      reset = 1'b0;

      // Standard palette, bright red.
      set_igrb(4'b1010);
      pulse_n(3);
      chk("bright_red", {8'h0, r_out, g_out, b_out}, 32'h00FF0000);
      chk("bright_red_de", {31'h0, de_out}, 32'h1);

      // Normal white, then blanked.
      set_igrb(4'b0111);
      pulse_n(3);
      chk("normal_white", {8'h0, r_out, g_out, b_out}, 32'h00D7D7D7);
      hblank = 1'b1;
      pulse_n(3);
      chk("hblank_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
      chk("hblank_flags", {30'h0, hbl_out, de_out}, 32'h2);
      hblank = 1'b0;

      // ULA+ colour and greyscale.
      uena = 1'b1; ucol = 8'b11100011;
      pulse_n(3);
      chk("ulap_colour", {8'h0, r_out, g_out, b_out}, 32'h0000FFFF);
      umono = 1'b1;
      pulse_n(3);
      chk("ulap_mono", {8'h0, r_out, g_out, b_out}, 32'h00B2B2B2);
      uena = 1'b0; umono = 1'b0;

      // mode512 mid-frame has no effect until VBlank rises.
      mode512 = 1'b1;
      pixcount = 0;
      pulse_pn(4);
      chk("lores_rate", pixcount, 4);
      chk("lores_hires", {31'h0, hires}, 32'h0);
      vblank = 1'b1;
      pulse_pn(2);
      vblank = 1'b0;
      pixcount = 0;
      pulse_pn(4);
      chk("hires_rate", pixcount, 8);
      chk("hires_flag", {31'h0, hires}, 32'h1);

      // HSync alignment with colour.
      set_igrb(4'b1010);
      pulse_n(3);
      hsync = 1'b1; in_b = 1'b1;
      pulse_n(1);
      hsync = 1'b0; in_b = 1'b0;
      pulse_n(1);
      chk("hsync_early", {31'h0, hs_out}, 32'h0);
      pulse_n(1);
      chk("hsync_aligned", {23'h0, hs_out, b_out}, 32'h1FF);
      pulse_n(1);
      chk("hsync_after", {31'h0, hs_out}, 32'h0);

      // Reset mid-line.
      reset = 1'b1; step();
      chk("midline_reset", {22'h0, ce_pix, de_out, hires, hs_out, vs_out, hbl_out, vbl_out,
                            r_out == 8'h00, g_out == 8'h00, b_out == 8'h00}, 32'h0000_0007);
      reset = 1'b0;
      pulse_n(2);
      chk("refill_2", {8'h0, r_out, g_out, b_out}, 32'h0);
      pulse_n(1);
      chk("refill_3", {8'h0, r_out, g_out, b_out}, 32'h00FF0000);
      chk("refill_3_de", {31'h0, de_out}, 32'h1);

      // Randomized traffic.
      repeat (4000) begin
         reset   = ($urandom_range(299) == 0);
         ce_7mp  = ($urandom_range(2) == 0);
         ce_7mn  = ($urandom_range(2) == 0);
         {in_i, in_r, in_g, in_b} = 4'($urandom);
         ucol    = 8'($urandom);
         uena    = ($urandom_range(1) == 0);
         umono   = ($urandom_range(1) == 0);
         mode512 = ($urandom_range(1) == 0);
         hsync   = ($urandom_range(7) == 0);
         vsync   = ($urandom_range(15) == 0);
         hblank  = ($urandom_range(3) == 0);
         if ($urandom_range(49) == 0) vblank = ~vblank;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
